// File: rtl/wb_scoreboard_pkg.sv
// Shared types and helpers for the write-back scoreboard.
// Hazard helper treats register 0 as "no register".
package wb_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  function automatic logic reg_hazard(
    input logic [NUM_REGS-1:0]   mask,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic [REG_ADDR_W-1:0] rd
  );
    return ((rs1 != 5'd0) && mask[rs1]) ||
           ((rs2 != 5'd0) && mask[rs2]) ||
           ((rd  != 5'd0) && mask[rd]);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Write-back result queue: two ordered push ports (a before b), one pop port.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
  import wb_scoreboard_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_a,
  input  wb_entry_t     data_a,
  input  logic          push_b,
  input  wb_entry_t     data_b,
  input  logic          pop,
  output wb_entry_t     head,
  output logic [CW-1:0] count
);

  wb_entry_t     mem_q [DEPTH];
  wb_entry_t     mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] slot_b_s;
  logic [CW-1:0] count_q, count_d;

  // Port b lands right behind port a when both push in one cycle.
  always_comb begin
    mem_d = mem_q;
    slot_b_s = push_a ? (wr_ptr_q + AW'(1'b1)) : wr_ptr_q;
    mem_d[wr_ptr_q] = push_a ? data_a : mem_q[wr_ptr_q];
    mem_d[slot_b_s] = push_b ? data_b : mem_d[slot_b_s];
    wr_ptr_d = wr_ptr_q + AW'(push_a) + AW'(push_b);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push_a) + CW'(push_b) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/wb_scoreboard.sv
// Write-back initiator with pending-destination scoreboard for the integer bank.
// Optional feature: WB_BYPASS_EN forwards the committing value and relaxes hazards.
module wb_scoreboard
  import wb_scoreboard_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  output logic                  issue_ready,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  regwrite,
  output logic [REG_ADDR_W-1:0] rdaddr,
  output logic [XLEN-1:0]       rddata,
  output logic                  err
`ifdef WB_BYPASS_EN
  ,
  output logic                  fwd_valid1,
  output logic                  fwd_valid2,
  output logic [XLEN-1:0]       fwd_data1,
  output logic [XLEN-1:0]       fwd_data2
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic [NUM_REGS-1:0]   clr_mask_s, set_mask_s, hazard_mask_s;
  logic                  regwrite_q, regwrite_d;
  logic [REG_ADDR_W-1:0] rdaddr_q, rdaddr_d;
  logic [XLEN-1:0]       rddata_q, rddata_d;
  logic                  err_q, err_d;

  logic [CW-1:0]         count_s, free_s;
  wb_entry_t             head_s, ld_ent_s, alu_ent_s, data_a_s;
  logic                  push_a_s, push_b_s, pop_s;
  logic                  ld_live_s, alu_live_s, issue_set_s;

  assign clr_mask_s = regwrite_q ? (NUM_REGS'(1) << rdaddr_q) : '0;

`ifdef WB_BYPASS_EN
  // The committing register is readable from the bypass, so it no longer hazards.
  assign hazard_mask_s = pending_q & ~clr_mask_s;
  assign fwd_valid1    = regwrite_q && (rdaddr_q != 5'd0) && (issue_rs1 == rdaddr_q);
  assign fwd_valid2    = regwrite_q && (rdaddr_q != 5'd0) && (issue_rs2 == rdaddr_q);
  assign fwd_data1     = rddata_q;
  assign fwd_data2     = rddata_q;
`else
  assign hazard_mask_s = pending_q;
`endif

  assign issue_ready = !reg_hazard(hazard_mask_s, issue_rs1, issue_rs2, issue_rd);
  assign issue_set_s = issue_valid && issue_ready && (issue_rd != 5'd0);
  assign set_mask_s  = issue_set_s ? (NUM_REGS'(1) << issue_rd) : '0;

  assign free_s    = CW'(DEPTH) - count_s;
  assign ld_ready  = (free_s >= CW'(1));
  assign alu_ready = (free_s >= CW'(2));

  assign ld_live_s  = ld_valid  && ld_ready  && (ld_rd  != 5'd0);
  assign alu_live_s = alu_valid && alu_ready && (alu_rd != 5'd0);
  assign ld_ent_s   = '{rd: ld_rd,  data: ld_data};
  assign alu_ent_s  = '{rd: alu_rd, data: alu_data};

  // Output register reload: queue head, else load, else ALU; spill the rest in order.
  always_comb begin
    push_a_s   = 1'b0;
    push_b_s   = 1'b0;
    data_a_s   = ld_ent_s;
    pop_s      = 1'b0;
    regwrite_d = 1'b0;
    rdaddr_d   = rdaddr_q;
    rddata_d   = rddata_q;
    if (count_s != CW'(0)) begin
      regwrite_d = 1'b1;
      rdaddr_d   = head_s.rd;
      rddata_d   = head_s.data;
      pop_s      = 1'b1;
      push_a_s   = ld_live_s;
      push_b_s   = alu_live_s;
    end else if (ld_live_s) begin
      regwrite_d = 1'b1;
      rdaddr_d   = ld_rd;
      rddata_d   = ld_data;
      push_a_s   = alu_live_s;
      data_a_s   = alu_ent_s;
    end else if (alu_live_s) begin
      regwrite_d = 1'b1;
      rdaddr_d   = alu_rd;
      rddata_d   = alu_data;
    end else begin
      regwrite_d = 1'b0;
    end
  end

  // Set wins over clear; a completion nobody is waiting for flags err.
  always_comb begin
    pending_d = ((pending_q & ~clr_mask_s) | set_mask_s) & ~NUM_REGS'(1);
    err_d = err_q
          | (ld_live_s  && !pending_q[ld_rd]  && !(issue_set_s && (issue_rd == ld_rd)))
          | (alu_live_s && !pending_q[alu_rd] && !(issue_set_s && (issue_rd == alu_rd)));
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_a (push_a_s),
    .data_a (data_a_s),
    .push_b (push_b_s),
    .data_b (alu_ent_s),
    .pop    (pop_s),
    .head   (head_s),
    .count  (count_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      regwrite_q <= 1'b0;
      rdaddr_q   <= '0;
      rddata_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      regwrite_q <= regwrite_d;
      rdaddr_q   <= rdaddr_d;
      rddata_q   <= rddata_d;
      err_q      <= err_d;
    end
  end

  assign regwrite = regwrite_q;
  assign rdaddr   = rdaddr_q;
  assign rddata   = rddata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Randomized bench for wb_scoreboard against a queue-based reference model.
// Honours WB_BYPASS_EN when the build defines it.
module tb_wb_scoreboard;

  localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        alu_valid, alu_ready, ld_valid, ld_ready;
  logic [4:0]  alu_rd, ld_rd;
  logic [31:0] alu_data, ld_data;
  logic        regwrite, err;
  logic [4:0]  rdaddr;
  logic [31:0] rddata;
`ifdef WB_BYPASS_EN
  logic        fwd_valid1, fwd_valid2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  always #5 clk = ~clk;

  wb_scoreboard #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .regwrite(regwrite), .rdaddr(rdaddr), .rddata(rddata), .err(err)
`ifdef WB_BYPASS_EN
    , .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;

  // Reference state: results waiting behind the write port, the write port, pending set.
  ent_t        m_q[$];
  logic [31:0] m_pend;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic m_reg_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    if (BYP && m_we && (m_addr == r)) return 1'b0;
    return m_pend[r];
  endfunction

  function automatic logic [4:0] pick_pending_rd();
    int cand[$];
    for (int i = 1; i < 32; i++) if (m_pend[i]) cand.push_back(i);
    if (cand.size() == 0 || $urandom_range(0, 5) == 0) return 5'd0;
    return 5'(cand[$urandom_range(0, cand.size() - 1)]);
  endfunction

  task automatic idle();
    issue_valid = 1'b0; issue_rd = 5'd0; issue_rs1 = 5'd0; issue_rs2 = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
  endtask

  // Called at the falling edge with inputs set; checks, then advances one clock.
  task automatic tick();
    logic        ir, ldr, alur, iacc, ne;
    logic [31:0] np;
    ent_t        all_q[$];
    ent_t        e;
    #1;
    ir   = !(m_reg_busy(issue_rs1) || m_reg_busy(issue_rs2) || m_reg_busy(issue_rd));
    ldr  = (DEPTH - m_q.size()) >= 1;
    alur = (DEPTH - m_q.size()) >= 2;
    check_eq("regwrite", regwrite, m_we);
    if (m_we) begin
      check_eq("rdaddr", rdaddr, m_addr);
      check_eq("rddata", rddata, m_data);
    end
    check_eq("issue_ready", issue_ready, ir);
    check_eq("ld_ready", ld_ready, ldr);
    check_eq("alu_ready", alu_ready, alur);
    check_eq("err", err, m_err);
`ifdef WB_BYPASS_EN
    check_eq("fwd_valid1", fwd_valid1, m_we && (m_addr != 5'd0) && (issue_rs1 == m_addr));
    check_eq("fwd_valid2", fwd_valid2, m_we && (m_addr != 5'd0) && (issue_rs2 == m_addr));
    if (fwd_valid1) check_eq("fwd_data1", fwd_data1, m_data);
`endif
    iacc = issue_valid && ir;
    np = m_pend;
    if (m_we) np[m_addr] = 1'b0;
    if (iacc && issue_rd != 5'd0) np[issue_rd] = 1'b1;
    np[0] = 1'b0;
    ne = m_err;
    all_q = m_q;
    if (ld_valid && ldr && ld_rd != 5'd0) begin
      all_q.push_back('{ld_rd, ld_data});
      if (!m_pend[ld_rd] && !(iacc && issue_rd == ld_rd)) ne = 1'b1;
    end
    if (alu_valid && alur && alu_rd != 5'd0) begin
      all_q.push_back('{alu_rd, alu_data});
      if (!m_pend[alu_rd] && !(iacc && issue_rd == alu_rd)) ne = 1'b1;
    end
    @(posedge clk);
    if (all_q.size() > 0) begin
      e = all_q.pop_front();
      m_we = 1'b1; m_addr = e.rd; m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    m_q = all_q;
    m_pend = np;
    m_err = ne;
    @(negedge clk);
  endtask

  // Asserts reset at a falling edge, checks cleared state at once, then releases.
  task automatic reset_and_check();
    rst_n = 1'b0;
    issue_rs1 = 5'd3; issue_rs2 = 5'd5; issue_rd = 5'd10;
    #1;
    check_eq("rst_regwrite", regwrite, 1'b0);
    check_eq("rst_rdaddr", rdaddr, 5'd0);
    check_eq("rst_rddata", rddata, 32'd0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_issue_ready", issue_ready, 1'b1);
    check_eq("rst_ld_ready", ld_ready, 1'b1);
    check_eq("rst_alu_ready", alu_ready, 1'b1);
    m_q.delete();
    m_pend = 32'd0; m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_err = 1'b0;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    reset_and_check();

    // Single ALU result: written one cycle after acceptance, hazard cleared after.
    issue_valid = 1'b1; issue_rd = 5'd5; tick();
    idle(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234; tick();
    idle(); issue_rd = 5'd5; #1;
    check_eq("x5_we", regwrite, 1'b1);
    check_eq("x5_addr", rdaddr, 5'd5);
    check_eq("x5_data", rddata, 32'h1234);
    check_eq("x5_commit_ready", issue_ready, BYP);
    tick();
    #1; check_eq("x5_cleared", issue_ready, 1'b1);
    tick();

    // RAW on x3 holds issue until the commit.
    issue_valid = 1'b1; issue_rd = 5'd3; tick();
    issue_rd = 5'd4; issue_rs1 = 5'd3; tick();
    #1; check_eq("x3_raw", issue_ready, 1'b0);
    tick();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33; tick();
    alu_valid = 1'b0; #1;
    check_eq("x3_commit_cycle", issue_ready, BYP);
`ifdef WB_BYPASS_EN
    check_eq("x3_fwd_data1", fwd_data1, 32'h33);
`endif
    tick();
    tick();
    idle(); alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44; tick();
    idle(); tick();

    // Load and ALU in the same cycle: load first.
    issue_valid = 1'b1; issue_rd = 5'd7; tick();
    issue_rd = 5'd8; tick();
    idle();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hA;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'hB;
    tick();
    idle(); #1;
    check_eq("pair_first_addr", rdaddr, 5'd7);
    check_eq("pair_first_data", rddata, 32'hA);
    tick();
    #1;
    check_eq("pair_second_we", regwrite, 1'b1);
    check_eq("pair_second_addr", rdaddr, 5'd8);
    check_eq("pair_second_data", rddata, 32'hB);
    tick();

    // Result for x0 is dropped silently.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD; tick();
    idle(); #1;
    check_eq("x0_no_write", regwrite, 1'b0);
    tick();
    #1; check_eq("x0_no_err", err, 1'b0);
    tick();

    // Random traffic; results only target pending registers so err stays clear.
    for (int c = 0; c < 300; c++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd  = 5'($urandom_range(0, 8));
      issue_rs1 = 5'($urandom_range(0, 8));
      issue_rs2 = 5'($urandom_range(0, 8));
      ld_valid  = ($urandom_range(0, 2) == 0);
      ld_rd     = pick_pending_rd();
      ld_data   = $urandom;
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd    = pick_pending_rd();
      alu_data  = $urandom;
      tick();
    end
    idle();
    repeat (8) tick();

    // Completion for a register nobody issued: written, err sticky.
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99; tick();
    idle(); #1;
    check_eq("x9_we", regwrite, 1'b1);
    check_eq("x9_addr", rdaddr, 5'd9);
    check_eq("x9_err", err, 1'b1);
    repeat (3) tick();
    #1; check_eq("x9_err_sticky", err, 1'b1);

    // Sustained load+ALU pairs saturate the queue.
    for (int c = 0; c < 10; c++) begin
      ld_valid = 1'b1; ld_rd = 5'(10 + (c % 4)); ld_data = $urandom;
      alu_valid = 1'b1; alu_rd = 5'(20 + (c % 4)); alu_data = $urandom;
      tick();
    end
    idle();
    issue_valid = 1'b1; issue_rd = 5'd12; tick();
    idle();

    // Reset with entries queued discards everything.
    reset_and_check();
    repeat (4) tick();
    for (int c = 0; c < 40; c++) begin
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rd  = 5'($urandom_range(0, 8));
      issue_rs1 = 5'($urandom_range(0, 8));
      issue_rs2 = 5'($urandom_range(0, 8));
      ld_valid  = ($urandom_range(0, 2) == 0);
      ld_rd     = pick_pending_rd();
      ld_data   = $urandom;
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd    = pick_pending_rd();
      alu_data  = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
